am_channel_scheduler: RTL and testbench

AM_CHANNEL_SCHEDULER -- requirements
Module: am_channel_scheduler

---
 rtl/am_sched_pkg.sv | 14 +
 rtl/am_channel_scheduler_cycle_timer.sv | 30 +++
 rtl/am_channel_scheduler.sv | 174 +++++++++++++++++
 tb/tb_am_channel_scheduler.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/am_sched_pkg.sv
// Shared types and defaults for the AM channel scheduler.
// Optional blanking between grants is controlled by the AM_SCHED_BLANK_EN macro.
package am_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        BLANK = 2'd2
    } sched_state_t;

    localparam int DEFAULT_WIDTH = 13;
    localparam int DEFAULT_NREQ  = 2;

endpackage

// File: rtl/am_channel_scheduler_cycle_timer.sv
// Free-running cycle counter with synchronous clear.
// tc pulses on the last cycle of each TERMINAL-cycle period, and the count wraps to zero there.
module cycle_timer #(
    parameter int TERMINAL = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    input  logic enable,
    output logic tc
);

    localparam int CW = (TERMINAL > 1) ? $clog2(TERMINAL) : 1;

    logic [CW-1:0] count;

    assign tc = enable && !load && (count == CW'(TERMINAL - 1));

    // Count enabled cycles, restarting from zero on load or at terminal count
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (enable) begin
            count <= tc ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/am_channel_scheduler.sv
// Time-shares one AM modulator between NREQ distance-sample requesters.
// Each grant lasts DWELL_CYCLES cycles; with AM_SCHED_BLANK_EN defined, a muted
// BLANK gap of BLANK_CYCLES separates grants, otherwise switches are immediate.
module am_channel_scheduler
    import am_sched_pkg::*;
#(
    parameter int WIDTH        = DEFAULT_WIDTH,
    parameter int NREQ         = DEFAULT_NREQ,
    parameter int DWELL_CYCLES = 1000000,
    parameter int BLANK_CYCLES = 64
) (
    input  logic                                     clk,
    input  logic                                     reset_n,
    input  logic [NREQ-1:0]                          req_valid,
    input  logic [NREQ*WIDTH-1:0]                    req_distance,
    output logic [NREQ-1:0]                          req_ready,
    output logic                                     mod_enable,
    output logic [WIDTH-1:0]                         mod_distance,
    output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] active_ch,
    output logic                                     busy
);

    localparam int CHW = (NREQ > 1) ? $clog2(NREQ) : 1;

    generate
        if (NREQ < 1 || DWELL_CYCLES < 1) begin : g_bad_params
            $error("am_channel_scheduler: NREQ and DWELL_CYCLES must be at least 1");
        end
`ifdef AM_SCHED_BLANK_EN
        if (BLANK_CYCLES < 2) begin : g_bad_blank
            $error("am_channel_scheduler: BLANK_CYCLES must be at least 2");
        end
`endif
    endgenerate

    sched_state_t   state;
    logic           dwell_tc;
    logic           low_found;
    logic [CHW-1:0] low_ch;
    logic           rr_found;
    logic [CHW-1:0] rr_ch;
    logic           xfer;
    logic [WIDTH-1:0] cur_distance;

    assign xfer         = req_valid[active_ch] && req_ready[active_ch];
    assign cur_distance = req_distance[active_ch*WIDTH +: WIDTH];

    cycle_timer #(.TERMINAL(DWELL_CYCLES)) u_dwell_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (state != DWELL),
        .enable  (state == DWELL),
        .tc      (dwell_tc)
    );

`ifdef AM_SCHED_BLANK_EN
    logic           blank_tc;
    logic [CHW-1:0] next_ch;
    logic           next_idle;

    cycle_timer #(.TERMINAL(BLANK_CYCLES)) u_blank_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (state != BLANK),
        .enable  (state == BLANK),
        .tc      (blank_tc)
    );
`endif

    // Find the lowest valid requester and the next valid one after active_ch in round-robin order
    always_comb begin
        int idx;
        idx       = 0;
        low_found = 1'b0;
        low_ch    = '0;
        rr_found  = 1'b0;
        rr_ch     = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                low_found = 1'b1;
                low_ch    = CHW'(i);
            end
        end
        for (int k = NREQ - 1; k >= 1; k--) begin
            idx = int'(active_ch) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (req_valid[idx]) begin
                rr_found = 1'b1;
                rr_ch    = CHW'(idx);
            end
        end
    end

    // Scheduler FSM with registered modulator and handshake outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            mod_enable   <= 1'b0;
            mod_distance <= '0;
            req_ready    <= '0;
            active_ch    <= '0;
            busy         <= 1'b0;
`ifdef AM_SCHED_BLANK_EN
            next_ch      <= '0;
            next_idle    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (low_found) begin
                        state      <= DWELL;
                        active_ch  <= low_ch;
                        req_ready  <= NREQ'(1) << low_ch;
                        mod_enable <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                DWELL: begin
                    if (xfer) mod_distance <= cur_distance;
                    if (dwell_tc) begin
                        if (rr_found) begin
`ifdef AM_SCHED_BLANK_EN
                            state        <= BLANK;
                            next_ch      <= rr_ch;
                            next_idle    <= 1'b0;
                            req_ready    <= '0;
                            mod_distance <= '0;
`else
                            active_ch    <= rr_ch;
                            req_ready    <= NREQ'(1) << rr_ch;
`endif
                        end else if (!req_valid[active_ch]) begin
`ifdef AM_SCHED_BLANK_EN
                            state        <= BLANK;
                            next_idle    <= 1'b1;
                            req_ready    <= '0;
                            mod_distance <= '0;
`else
                            state        <= IDLE;
                            mod_enable   <= 1'b0;
                            mod_distance <= '0;
                            req_ready    <= '0;
                            busy         <= 1'b0;
`endif
                        end
                    end
                end
`ifdef AM_SCHED_BLANK_EN
                BLANK: begin
                    if (blank_tc) begin
                        if (next_idle) begin
                            state      <= IDLE;
                            mod_enable <= 1'b0;
                            busy       <= 1'b0;
                        end else begin
                            state     <= DWELL;
                            active_ch <= next_ch;
                            req_ready <= NREQ'(1) << next_ch;
                        end
                    end
                end
`endif
                default: begin
                    state        <= IDLE;
                    mod_enable   <= 1'b0;
                    mod_distance <= '0;
                    req_ready    <= '0;
                    busy         <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_am_channel_scheduler.sv
// Self-checking bench for am_channel_scheduler (NREQ=2, DWELL_CYCLES=8, BLANK_CYCLES=4).
// The reference model follows AM_SCHED_BLANK_EN the same way the design build does.
module tb_am_channel_scheduler;

    localparam int WIDTH = 13;
    localparam int NREQ  = 2;
    localparam int DWELL = 8;
    localparam int BLANKC = 4;
`ifdef AM_SCHED_BLANK_EN
    localparam bit BLANK_ON = 1'b1;
`else
    localparam bit BLANK_ON = 1'b0;
`endif

    logic                  clk;
    logic                  reset_n;
    logic [NREQ-1:0]       req_valid;
    logic [WIDTH-1:0]      dist_in [NREQ];
    logic [NREQ*WIDTH-1:0] req_distance;
    logic [NREQ-1:0]       req_ready;
    logic                  mod_enable;
    logic [WIDTH-1:0]      mod_distance;
    logic                  active_ch;
    logic                  busy;

    int assert_count;
    int fail_count;

    // Model: phase 0 idle, 1 dwell, 2 blank; m_left counts cycles remaining in the phase
    int m_phase;
    int m_ch;
    int m_left;
    int m_next;
    int m_next_idle;
    int m_dist;

    assign req_distance = {dist_in[1], dist_in[0]};

    am_channel_scheduler #(
        .WIDTH        (WIDTH),
        .NREQ         (NREQ),
        .DWELL_CYCLES (DWELL),
        .BLANK_CYCLES (BLANKC)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_distance (req_distance),
        .req_ready    (req_ready),
        .mod_enable   (mod_enable),
        .mod_distance (mod_distance),
        .active_ch    (active_ch),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic modelReset();
        m_phase     = 0;
        m_ch        = 0;
        m_left      = 0;
        m_next      = 0;
        m_next_idle = 0;
        m_dist      = 0;
    endtask

    task automatic modelStep(input logic [NREQ-1:0] v, input int d0, input int d1);
        int d [NREQ];
        int nd;
        int other;
        int idx;
        d[0] = d0;
        d[1] = d1;
        case (m_phase)
            0: begin
                if (v != 0) begin
                    m_ch    = v[0] ? 0 : 1;
                    m_phase = 1;
                    m_left  = DWELL;
                end
            end
            1: begin
                nd = v[m_ch] ? d[m_ch] : m_dist;
                m_left--;
                if (m_left == 0) begin
                    other = -1;
                    for (int k = 1; k < NREQ; k++) begin
                        idx = (m_ch + k) % NREQ;
                        if (other < 0 && v[idx]) other = idx;
                    end
                    if (other >= 0) begin
                        if (BLANK_ON) begin
                            m_phase = 2; m_left = BLANKC; m_next = other; m_next_idle = 0; m_dist = 0;
                        end else begin
                            m_ch = other; m_left = DWELL; m_dist = nd;
                        end
                    end else if (v[m_ch]) begin
                        m_left = DWELL; m_dist = nd;
                    end else if (BLANK_ON) begin
                        m_phase = 2; m_left = BLANKC; m_next_idle = 1; m_dist = 0;
                    end else begin
                        m_phase = 0; m_dist = 0;
                    end
                end else begin
                    m_dist = nd;
                end
            end
            default: begin
                m_left--;
                if (m_left == 0) begin
                    if (m_next_idle != 0) begin
                        m_phase = 0;
                    end else begin
                        m_phase = 1; m_ch = m_next; m_left = DWELL;
                    end
                end
            end
        endcase
    endtask

    task automatic checkOutput(input string tag);
        logic [NREQ-1:0]  exp_ready;
        logic [WIDTH-1:0] exp_dist;
        exp_ready = (m_phase == 1) ? NREQ'(1 << m_ch) : '0;
        exp_dist  = WIDTH'(m_dist);
        assert_count++;
        assert (mod_enable === (m_phase != 0)) else begin
            fail_count++;
            $error("[TB] FAIL %s mod_enable observed=%0b expected=%0b", tag, mod_enable, m_phase != 0);
        end
        assert_count++;
        assert (busy === (m_phase != 0)) else begin
            fail_count++;
            $error("[TB] FAIL %s busy observed=%0b expected=%0b", tag, busy, m_phase != 0);
        end
        assert_count++;
        assert (mod_distance === exp_dist) else begin
            fail_count++;
            $error("[TB] FAIL %s mod_distance observed=%0d expected=%0d", tag, mod_distance, exp_dist);
        end
        assert_count++;
        assert (req_ready === exp_ready) else begin
            fail_count++;
            $error("[TB] FAIL %s req_ready observed=%b expected=%b", tag, req_ready, exp_ready);
        end
        assert_count++;
        assert (active_ch === 1'(m_ch)) else begin
            fail_count++;
            $error("[TB] FAIL %s active_ch observed=%0d expected=%0d", tag, active_ch, m_ch);
        end
    endtask

    // One clock: model advances on the rising edge, outputs are checked on the falling edge
    task automatic applyStimulus(input logic [NREQ-1:0] v, input int d0, input int d1,
                                 input int ncycles, input string tag);
        req_valid  = v;
        dist_in[0] = WIDTH'(d0);
        dist_in[1] = WIDTH'(d1);
        for (int c = 0; c < ncycles; c++) begin
            @(posedge clk);
            if (reset_n) modelStep(v, d0, d1);
            else modelReset();
            @(negedge clk);
            checkOutput(tag);
        end
    endtask

    initial begin
        logic [NREQ-1:0] rv;
        int rd0;
        int rd1;
        assert_count = 0;
        fail_count   = 0;
        reset_n      = 1'b0;
        req_valid    = '0;
        dist_in[0]   = '0;
        dist_in[1]   = '0;
        modelReset();
        #1;
        checkOutput("reset_state");
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        $display("[TB] idle with no requests");
        applyStimulus(2'b00, 0, 0, 20, "idle_quiet");

        $display("[TB] single requester ch0");
        applyStimulus(2'b01, 1500, 0, 20, "single_ch0");

        $display("[TB] both requesters alternate");
        applyStimulus(2'b11, 100, 2000, 40, "both_alt");

        $display("[TB] both drop valid during a dwell");
        applyStimulus(2'b00, 100, 2000, 20, "drop_all");

        $display("[TB] reset in the middle of a dwell");
        applyStimulus(2'b01, 777, 0, 3, "pre_reset");
        reset_n = 1'b0;
        #1;
        modelReset();
        checkOutput("async_reset");
        applyStimulus(2'b10, 0, 333, 2, "in_reset");
        reset_n = 1'b1;
        applyStimulus(2'b10, 0, 333, 12, "post_reset_ch1");

        $display("[TB] mixed and maximum distances");
        applyStimulus(2'b11, 8191, 0, 30, "max_distance");

        $display("[TB] randomized traffic");
        rv  = 2'b11;
        rd0 = 1;
        rd1 = 2;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 9) == 0) rv = NREQ'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) rd0 = int'($urandom_range(0, 8191));
            if ($urandom_range(0, 3) == 0) rd1 = int'($urandom_range(0, 8191));
            applyStimulus(rv, rd0, rd1, 1, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
